// File: rtl/mul_div_sequencer_if.sv
// Request/result handshake plus the borrowed-ALU bus for mul_div_sequencer.
// slave = the sequencer, master = the datapath top that feeds it and owns the ALU.
interface mul_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             startValid;
  logic             startReady;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             resultValid;
  logic             resultReady;
  logic [WIDTH-1:0] result;
  logic             aluReq;
  logic [3:0]       aluSel;
  logic [WIDTH-1:0] aluIn1;
  logic [WIDTH-1:0] aluIn2;
  logic [WIDTH-1:0] aluResult;

  modport slave (
    input  startValid, op, opA, opB, resultReady, aluResult,
    output startReady, resultValid, result, aluReq, aluSel, aluIn1, aluIn2
  );

  modport master (
    output startValid, op, opA, opB, resultReady, aluResult,
    input  startReady, resultValid, result, aluReq, aluSel, aluIn1, aluIn2
  );
endinterface

// File: rtl/mul_div_sequencer.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU. Owns no adder: every iteration
// borrows the shared ALU (ADD for shift-add multiply, SUB for restoring divide).
// Registers are shared between the two algorithms:
//   acc = hi (mul) / rem (div), sh = lo (mul) / quo (div), dv = mc (mul) / dv (div).
module mul_div_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110
) (
  input logic                clk,
  input logic                rst_n,
  mul_div_sequencer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc, sh, dv, res;
  logic [WIDTH-1:0] acc_nxt, sh_nxt, r1;
  logic             msb, carry, last;
  logic             div0;

  assign div0 = bus.op[1] & (bus.opB == '0);
  assign last = (cnt == CW'(WIDTH - 1));

  assign bus.startReady  = (state == IDLE);
  assign bus.resultValid = (state == DONE);
  assign bus.result      = res;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and ALU request; the ALU bus is quiet outside ITER
  always_comb begin
    state_nxt  = state;
    bus.aluReq = 1'b0;
    bus.aluSel = 4'b0000;
    bus.aluIn1 = '0;
    bus.aluIn2 = '0;
    case (state)
      IDLE: if (bus.startValid) state_nxt = div0 ? DONE : ITER;
      ITER: begin
        bus.aluReq = 1'b1;
        bus.aluSel = op_q[1] ? ALU_SUB : ALU_ADD;
        bus.aluIn1 = op_q[1] ? r1 : acc;
        bus.aluIn2 = dv;
        if (last) state_nxt = DONE;
      end
      DONE: if (bus.resultReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration of either algorithm; carry/borrow are local compares only
  always_comb begin
    msb     = acc[WIDTH-1];
    r1      = {acc[WIDTH-2:0], sh[WIDTH-1]};
    carry   = (bus.aluResult < acc);
    acc_nxt = acc;
    sh_nxt  = sh;
    if (op_q[1]) begin
      if (msb | (r1 >= dv)) begin
        acc_nxt = bus.aluResult;
        sh_nxt  = {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = r1;
        sh_nxt  = {sh[WIDTH-2:0], 1'b0};
      end
    end else if (sh[0]) begin
      acc_nxt = {carry, bus.aluResult[WIDTH-1:1]};
      sh_nxt  = {bus.aluResult[0], sh[WIDTH-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[WIDTH-1:1]};
      sh_nxt  = {acc[0], sh[WIDTH-1:1]};
    end
  end

  // Operand load, iteration update, result capture on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      op_q <= '0;
      acc  <= '0;
      sh   <= '0;
      dv   <= '0;
      res  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.startValid) begin
          op_q <= bus.op;
          cnt  <= '0;
          acc  <= '0;
          sh   <= bus.op[1] ? bus.opA : bus.opB;
          dv   <= bus.op[1] ? bus.opB : bus.opA;
          // RISC-V divide by zero: quotient all ones, remainder = dividend
          if (div0) res <= bus.op[0] ? bus.opA : '1;
        end
        ITER: begin
          acc <= acc_nxt;
          sh  <= sh_nxt;
          cnt <= cnt + CW'(1);
          if (last) res <= op_q[0] ? acc_nxt : sh_nxt;
        end
        DONE: if (bus.resultReady) res <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer: vector table plus backpressure and
// mid-operation reset sequences. The shared ALU is modelled here.
module tb_mul_div_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_div_sequencer_if #(.WIDTH(W)) bus ();

  mul_div_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared ALU
  always_comb begin
    case (bus.aluSel)
      4'b0000: bus.aluResult = bus.aluIn1 & bus.aluIn2;
      4'b0001: bus.aluResult = bus.aluIn1 | bus.aluIn2;
      4'b0010: bus.aluResult = bus.aluIn1 + bus.aluIn2;
      4'b0110: bus.aluResult = bus.aluIn1 - bus.aluIn2;
      default: bus.aluResult = '0;
    endcase
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vec[14];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Present a request at the falling edge; it is taken at the next rising edge
  task automatic issue(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    check({nm, "_startReady"}, W'(bus.startReady), W'(1));
    bus.startValid = 1'b1;
    bus.op = op;
    bus.opA = a;
    bus.opB = b;
    @(posedge clk);
    #1 bus.startValid = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the accepting edge
  task automatic collect(input string nm, input logic [W-1:0] exp, input int lat);
    int k = 1;
    int alu_cyc = 0;
    @(negedge clk);
    while (!bus.resultValid && k < 200) begin
      if (bus.aluReq) alu_cyc++;
      k++;
      @(negedge clk);
    end
    check({nm, "_latency"}, W'(k), W'(lat));
    check({nm, "_result"}, bus.result, exp);
    check({nm, "_aluReq_cycles"}, W'(alu_cyc), W'(lat - 1));
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.resultReady = 1'b1;
    @(posedge clk);
    #1 bus.resultReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{2'b00, 32'd7,        32'd6,        32'h0000_002A, 33};
    vec[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vec[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
    vec[3]  = '{2'b10, 32'd100,      32'd7,        32'd14,        33};
    vec[4]  = '{2'b11, 32'd100,      32'd7,        32'd2,         33};
    vec[5]  = '{2'b10, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 33};
    vec[6]  = '{2'b11, 32'hFFFF_FFFF, 32'd1,       32'd0,         33};
    vec[7]  = '{2'b10, 32'd5,        32'd0,        32'hFFFF_FFFF, 1};
    vec[8]  = '{2'b11, 32'd5,        32'd0,        32'd5,         1};
    vec[9]  = '{2'b01, 32'h8000_0000, 32'd2,       32'd1,         33};
    vec[10] = '{2'b00, 32'h1234_5678, 32'd0,       32'd0,         33};
    vec[11] = '{2'b10, 32'd3,        32'd10,       32'd0,         33};
    vec[12] = '{2'b11, 32'd3,        32'd10,       32'd3,         33};
    vec[13] = '{2'b00, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 33};

    bus.startValid = 1'b0;
    bus.op = 2'b00;
    bus.opA = '0;
    bus.opB = '0;
    bus.resultReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_startReady", W'(bus.startReady), W'(1));
    check("rst_resultValid", W'(bus.resultValid), W'(0));
    check("rst_result", bus.result, '0);
    check("rst_aluReq", W'(bus.aluReq), W'(0));
    check("rst_aluSel", W'(bus.aluSel), W'(0));
    check("rst_aluIn1", bus.aluIn1, '0);

    foreach (vec[i]) begin
      issue($sformatf("vec%0d", i), vec[i].op, vec[i].a, vec[i].b);
      collect($sformatf("vec%0d", i), vec[i].exp, vec[i].lat);
      release_result();
    end

    // Backpressure: result held, new requests ignored, then back-to-back op
    issue("bp", 2'b00, 32'd7, 32'd6);
    collect("bp", 32'h2A, 33);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", W'(bus.resultValid), W'(1));
      check("bp_hold_result", bus.result, 32'h2A);
      check("bp_hold_startReady", W'(bus.startReady), W'(0));
      bus.startValid = 1'b1;
      bus.op = 2'b10;
      bus.opA = 32'd5;
      bus.opB = 32'd0;
      @(negedge clk);
    end
    bus.op = 2'b10;
    bus.opA = 32'd9;
    bus.opB = 32'd3;
    bus.resultReady = 1'b1;
    @(posedge clk);
    #1 bus.resultReady = 1'b0;
    @(negedge clk);
    check("bp_after_startReady", W'(bus.startReady), W'(1));
    check("bp_after_resultValid", W'(bus.resultValid), W'(0));
    @(posedge clk);
    #1 bus.startValid = 1'b0;
    collect("bp_next", 32'd3, 33);
    release_result();

    // Reset in the middle of an operation
    issue("mrst", 2'b00, 32'hFFFF_FFFF, 32'd3);
    repeat (15) @(negedge clk);
    check("mrst_busy_aluReq", W'(bus.aluReq), W'(1));
    check("mrst_busy_result", bus.result, '0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mrst_startReady", W'(bus.startReady), W'(1));
    check("mrst_resultValid", W'(bus.resultValid), W'(0));
    check("mrst_aluReq", W'(bus.aluReq), W'(0));
    check("mrst_result", bus.result, '0);
    repeat (40) @(negedge clk);
    check("mrst_no_stale_result", W'(bus.resultValid), W'(0));
    issue("mrst_next", 2'b10, 32'd100, 32'd7);
    collect("mrst_next", 32'd14, 33);
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
